// File: rtl/uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer
//
// Oversampling UART receive framer. The raw line is synchronised, a falling
// edge opens a frame, the start bit is re-checked at its middle, and every
// following bit (data LSB first, optional parity, stop) is sampled in the middle
// of its bit period by counting baud_tick pulses. At the end of each frame the
// assembled word and the sampled stop level are handed to the downstream stop
// checker together with a one-cycle check_stop strobe.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          asynchronous active-high reset
//   baud_tick    one-CLK pulse, OVERSAMPLE pulses per bit period
//   RX_in        raw asynchronous serial line, idle high
//   data_out     last received data word (holds until next check_stop)
//   stop_bit     sampled stop level of the last frame
//   check_stop   one-CLK strobe: data_out/stop_bit/parity_error updated
//   parity_error parity mismatch on the last frame (0 when PARITY_EN=0)
//   busy         high whenever the framer is not idle
// -----------------------------------------------------------------------------
module uart_rx_deframer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 baud_tick,
  input  logic                 RX_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 stop_bit,
  output logic                 check_stop,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int   TICK_W = $clog2(OVERSAMPLE);
  localparam int   BIT_W  = $clog2(DATA_BITS);
  localparam logic ODD    = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state, state_next;
  logic                 rx_meta, rx_s;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_err_q;

  logic half_tick, full_tick;
  logic shift_en, par_en, stop_en;

  // Two-flop synchroniser; resets to the idle (high) line level so that
  // leaving reset never looks like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, exactly like the hardware.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_in;
      rx_s    <= rx_meta;
    end
  end

  // Middle of the start bit, and middle of every later bit measured from
  // the previous sample point.
  assign half_tick = baud_tick && (tick_cnt == TICK_W'(OVERSAMPLE/2 - 1));
  assign full_tick = baud_tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    stop_en    = 1'b0;
    case (state)
      S_IDLE:   if (!rx_s) state_next = S_START;
      S_START:  if (half_tick) state_next = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (full_tick) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1))
            state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (full_tick) begin
          par_en     = 1'b1;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (full_tick) begin
          stop_en    = 1'b1;
          // A low stop bit may be a held-low (break) line; wait for it to
          // return high before arming for a new frame.
          state_next = rx_s ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK:  if (rx_s) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Tick counter: restarts on every state change, counts baud ticks only
  // while a frame is in progress and wraps once per bit period.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_cnt <= '0;
    end else if (state_next != state) begin
      tick_cnt <= '0;
    end else if (baud_tick && state != S_IDLE && state != S_BREAK) begin
      if (tick_cnt == TICK_W'(OVERSAMPLE - 1)) tick_cnt <= '0;
      else                                     tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Data path: shift in LSB first, evaluate parity once the word is
  // complete, publish everything together at the stop-bit sample.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt      <= '0;
      shift_reg    <= '0;
      par_err_q    <= 1'b0;
      data_out     <= '0;
      stop_bit     <= 1'b1;
      check_stop   <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      check_stop <= stop_en;
      if (shift_en) begin
        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
        if (bit_cnt == BIT_W'(DATA_BITS - 1)) bit_cnt <= '0;
        else                                  bit_cnt <= bit_cnt + BIT_W'(1);
      end
      if (par_en)
        par_err_q <= ((^shift_reg) ^ rx_s) != ODD;
      if (stop_en) begin
        data_out     <= shift_reg;
        stop_bit     <= rx_s;
        parity_error <= (PARITY_EN != 0) && par_err_q;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule
